// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// width computation for the interval down-counter.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 1) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Down-counter width; never zero so a 1-cycle HOLD/GAP still has a register.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
        int unsigned m;
        m = (hold > gap) ? hold : gap;
        return (clog2(m) < 1) ? 1 : clog2(m);
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / stretched-level-out bundle of the pulse stretcher.
interface pulse_stretcher_if #(
    parameter int unsigned PEND_W = 3
);
    logic              pulse_in;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (output pulse_in, input level_out, busy, pending, overflow);
    modport slave  (input pulse_in, output level_out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up/down event counter with a sticky flag for increments lost at
// saturation; a simultaneous inc and dec leaves the count unchanged.
module sat_up_down_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow
);
    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == MAX) overflow <= 1'b1;
            else              count    <= count + W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - W'(1);
        end
    end
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HOLD_CYCLES-wide high intervals separated
// by GAP_CYCLES low cycles, queuing overlapping events. Define
// PULSE_STRETCH_RETRIG_EN to make a strobe during HOLD extend the interval.
module pulse_stretcher
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    pulse_stretcher_if.slave bus
);
    localparam int unsigned      CNT_W     = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pend_inc, pend_dec;
    logic [PEND_W-1:0] pend_cnt;
    logic              pend_ovf;
    logic              level_q, busy_q;

    // State, counter and output flops; outputs are loaded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_q <= (state_nxt == HOLD);
            busy_q  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_inc  = 1'b0;
        pend_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.pulse_in) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            HOLD: begin
`ifdef PULSE_STRETCH_RETRIG_EN
                if (bus.pulse_in) begin
                    cnt_nxt = HOLD_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
`else
                pend_inc = bus.pulse_in;
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
`endif
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt  = cnt - CNT_W'(1);
                    pend_inc = bus.pulse_in;
                end else if (pend_cnt != '0) begin
                    // Queued events go first; a same-cycle strobe joins the queue.
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                    pend_dec  = 1'b1;
                    pend_inc  = bus.pulse_in;
                end else if (bus.pulse_in) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    sat_up_down_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .inc      (pend_inc),
        .dec      (pend_dec),
        .count    (pend_cnt),
        .overflow (pend_ovf)
    );

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pend_cnt;
    assign bus.overflow  = pend_ovf;
endmodule
